// File: rtl/user_reg_sequencer_if.sv
// Command and register-side signal bundle for user_reg_sequencer.
// master: CPU control side issuing commands; slave: the sequencer itself.
interface user_reg_sequencer_if #(
  parameter int WIDTH = 19,
  parameter int CNT_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [WIDTH-1:0] CMD_DATA;
  logic [CNT_W-1:0] CMD_REPEAT;
  logic [WIDTH-1:0] REG_DATA;
  logic             LOAD;
  logic             INC;
  logic             DEC;
  logic             CLR;
  logic [WIDTH-1:0] SHADOW;
  logic             BUSY;
  logic             DONE;
  logic             SAT;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DATA, CMD_REPEAT,
    input  CMD_READY, REG_DATA, LOAD, INC, DEC, CLR, SHADOW, BUSY, DONE, SAT
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DATA, CMD_REPEAT,
    output CMD_READY, REG_DATA, LOAD, INC, DEC, CLR, SHADOW, BUSY, DONE, SAT
  );
endinterface

// File: rtl/user_reg_sequencer.sv
// Expands LOAD/INC/DEC/CLR commands into one-hot strobe trains for a user register.
// Optional USER_REG_SATURATE_EN suppresses INC at all-ones / DEC at zero and sets sticky SAT.
//
// state | meaning
// INIT  | after reset: one CLR strobe to resync the register
// IDLE  | ready for a command
// ISSUE | one strobe (or suppressed slot) per cycle until count exhausted
// FIN   | DONE pulse
module user_reg_sequencer #(
  parameter int WIDTH = 19,
  parameter int CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  user_reg_sequencer_if.slave bus
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, FIN} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t           state, state_nxt;
  logic [1:0]       op, op_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic             load, load_nxt;
  logic             inc, inc_nxt;
  logic             dec, dec_nxt;
  logic             clr, clr_nxt;
  logic             ready, ready_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             sat, sat_nxt;
  logic             issue;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= INIT;
      op     <= OP_LOAD;
      cnt    <= '0;
      data   <= '0;
      shadow <= '0;
      load   <= 1'b0;
      inc    <= 1'b0;
      dec    <= 1'b0;
      clr    <= 1'b0;
      ready  <= 1'b0;
      busy   <= 1'b1;
      done   <= 1'b0;
      sat    <= 1'b0;
    end else begin
      state  <= state_nxt;
      op     <= op_nxt;
      cnt    <= cnt_nxt;
      data   <= data_nxt;
      shadow <= shadow_nxt;
      load   <= load_nxt;
      inc    <= inc_nxt;
      dec    <= dec_nxt;
      clr    <= clr_nxt;
      ready  <= ready_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      sat    <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    cnt_nxt   = cnt;
    data_nxt  = data;
    load_nxt  = 1'b0;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    ready_nxt = 1'b0;
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;
    issue     = 1'b0;
`ifdef USER_REG_SATURATE_EN
    sat_nxt   = sat;
`else
    sat_nxt   = 1'b0;
`endif

    // Shadow follows the strobe the register samples on this same edge.
    if (load)     shadow_nxt = data;
    else if (inc) shadow_nxt = shadow + WIDTH'(1);
    else if (dec) shadow_nxt = shadow - WIDTH'(1);
    else if (clr) shadow_nxt = '0;
    else          shadow_nxt = shadow;

    case (state)
      INIT: begin
        if (!clr) begin
          clr_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (bus.CMD_VALID && ready) begin
          state_nxt = ISSUE;
          op_nxt    = bus.CMD_OP;
          data_nxt  = bus.CMD_DATA;
          cnt_nxt   = ((bus.CMD_OP == OP_INC || bus.CMD_OP == OP_DEC) && bus.CMD_REPEAT != '0)
                      ? bus.CMD_REPEAT : CNT_W'(1);
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
          issue     = 1'b1;
        end
      end
      ISSUE: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
        end else begin
          issue = 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = INIT;
    endcase

    // Saturation decision uses the value the register will hold when this strobe lands.
    if (issue) begin
      case (op_nxt)
        OP_LOAD: load_nxt = 1'b1;
        OP_INC: begin
`ifdef USER_REG_SATURATE_EN
          if (&shadow_nxt) sat_nxt = 1'b1;
          else             inc_nxt = 1'b1;
`else
          inc_nxt = 1'b1;
`endif
        end
        OP_DEC: begin
`ifdef USER_REG_SATURATE_EN
          if (shadow_nxt == '0) sat_nxt = 1'b1;
          else                  dec_nxt = 1'b1;
`else
          dec_nxt = 1'b1;
`endif
        end
        default: clr_nxt = 1'b1;
      endcase
    end
  end

  assign bus.CMD_READY = ready;
  assign bus.REG_DATA  = data;
  assign bus.LOAD      = load;
  assign bus.INC       = inc;
  assign bus.DEC       = dec;
  assign bus.CLR       = clr;
  assign bus.SHADOW    = shadow;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.SAT       = sat;

endmodule

// File: tb/tb_user_reg_sequencer.sv
// Randomized bench for user_reg_sequencer against a value-level model of the register.
module tb_user_reg_sequencer;
  localparam int WIDTH = 19;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef USER_REG_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  user_reg_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  user_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_shadow = 0;
  bit exp_sat = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.LOAD, bus.INC, bus.DEC, bus.CLR};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_in_reset();
    check("rst_strobes", strobes(), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_sat", 32'(bus.SAT), 32'd0);
    check("rst_shadow", 32'(bus.SHADOW), 32'd0);
    check("rst_regdata", 32'(bus.REG_DATA), 32'd0);
    check("rst_ready", 32'(bus.CMD_READY), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd1);
  endtask

  // Call right after RST_N rises between edges.
  task automatic init_after_release();
    step();
    check("init_clr", strobes(), 32'd1);
    check("init_ready", 32'(bus.CMD_READY), 32'd0);
    check("init_busy", 32'(bus.BUSY), 32'd1);
    step();
    check("init_strobes_off", strobes(), 32'd0);
    check("init_ready_up", 32'(bus.CMD_READY), 32'd1);
    check("init_busy_off", 32'(bus.BUSY), 32'd0);
    check("init_shadow", 32'(bus.SHADOW), 32'd0);
    exp_shadow = 0;
    exp_sat    = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input int data, input int rep);
    int n;
    int w;
    logic [31:0] exp_str;
    w = 0;
    while (bus.CMD_READY !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("ready_before_cmd", 32'(bus.CMD_READY), 32'd1);
    bus.CMD_VALID  = 1'b1;
    bus.CMD_OP     = op;
    bus.CMD_DATA   = WIDTH'(data);
    bus.CMD_REPEAT = CNT_W'(rep);
    step();
    n = (op == 2'b01 || op == 2'b10) ? ((rep == 0) ? 1 : rep) : 1;
    for (int i = 0; i < n; i++) begin
      check("shadow_pre", 32'(bus.SHADOW), 32'(exp_shadow));
      case (op)
        2'b00: begin
          exp_str = 32'd8;
          check("load_regdata", 32'(bus.REG_DATA), 32'(data & MAXV));
          exp_shadow = data & MAXV;
        end
        2'b01: begin
          if (SAT_EN && exp_shadow == MAXV) begin
            exp_str = 32'd0;
            exp_sat = 1'b1;
          end else begin
            exp_str = 32'd4;
            exp_shadow = (exp_shadow + 1) & MAXV;
          end
        end
        2'b10: begin
          if (SAT_EN && exp_shadow == 0) begin
            exp_str = 32'd0;
            exp_sat = 1'b1;
          end else begin
            exp_str = 32'd2;
            exp_shadow = (exp_shadow - 1) & MAXV;
          end
        end
        default: begin
          exp_str = 32'd1;
          exp_shadow = 0;
        end
      endcase
      check("strobe", strobes(), exp_str);
      check("done_early", 32'(bus.DONE), 32'd0);
      check("ready_busy", 32'(bus.CMD_READY), 32'd0);
      check("busy_issue", 32'(bus.BUSY), 32'd1);
      // Garbage on the command bus while busy must not disturb the latched command.
      bus.CMD_VALID  = 1'($urandom_range(0, 1));
      bus.CMD_OP     = 2'($urandom);
      bus.CMD_DATA   = WIDTH'($urandom);
      bus.CMD_REPEAT = CNT_W'($urandom);
      step();
    end
    check("done", 32'(bus.DONE), 32'd1);
    check("done_strobes", strobes(), 32'd0);
    check("done_shadow", 32'(bus.SHADOW), 32'(exp_shadow));
    check("done_sat", 32'(bus.SAT), 32'(exp_sat));
    check("done_ready", 32'(bus.CMD_READY), 32'd0);
    bus.CMD_VALID = 1'b0;
    step();
    check("ready_after", 32'(bus.CMD_READY), 32'd1);
    check("done_once", 32'(bus.DONE), 32'd0);
    check("busy_after", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic reset_mid_inc();
    while (bus.CMD_READY !== 1'b1) step();
    bus.CMD_VALID  = 1'b1;
    bus.CMD_OP     = 2'b01;
    bus.CMD_DATA   = '0;
    bus.CMD_REPEAT = CNT_W'(10);
    step();
    bus.CMD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mid_inc_strobe", strobes(), SAT_EN && exp_shadow == MAXV ? 32'd0 : 32'd4);
      if (!(SAT_EN && exp_shadow == MAXV)) exp_shadow = (exp_shadow + 1) & MAXV;
      step();
    end
    #2 RST_N = 1'b0;
    #1;
    check_in_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_no_done", 32'(bus.DONE), 32'd0);
      check("rst_hold_strobes", strobes(), 32'd0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    init_after_release();
  endtask

  int rdata;
  logic [1:0] rop;

  initial begin
    bus.CMD_VALID  = 1'b0;
    bus.CMD_OP     = 2'b00;
    bus.CMD_DATA   = '0;
    bus.CMD_REPEAT = '0;
    #1 RST_N = 1'b0;
    #2;
    check_in_reset();
    step();
    step();
    check_in_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    init_after_release();

    run_cmd(2'b00, 32'h12345, 0);
    run_cmd(2'b00, 5, 0);
    run_cmd(2'b01, 0, 3);
    run_cmd(2'b01, 0, 0);
    run_cmd(2'b00, 32'h7FFFE, 0);
    run_cmd(2'b01, 0, 3);
    run_cmd(2'b11, 0, 7);
    run_cmd(2'b10, 0, 2);
    run_cmd(2'b00, 0, 0);
    run_cmd(2'b10, 0, 0);
    reset_mid_inc();

    for (int t = 0; t < 40; t++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rdata = 0;
        1:       rdata = MAXV;
        2:       rdata = MAXV - 1;
        default: rdata = int'($urandom_range(0, MAXV));
      endcase
      run_cmd(rop, rdata, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
